fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side drain engine for the team's synchronous flip-flop FIFOs with registered read data. It issues `fifo_rd_en` to the FIFO and captures each returned word one cycle later. Returned words go into a 2-entry holding buffer, which presents them on a valid/ready stream. The block sits between any registered-output sync FIFO and a downstream consumer. It sustains one word per cycle and never drops or duplicates a word under back-pressure.

## Interface
- `WIDTH`, 32: data word width; must match the FIFO.
- `CNT_W`, 32: width of the delivered-word counter.
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `fifo_empty`  in  1  FIFO empty flag (registered in FIFO); 1 = no readable word this cycle.
- `fifo_rd_data`  in  WIDTH  FIFO read data; valid only in the cycle after an accepted read.
- `fifo_rd_en`  out  1  read request to FIFO (combinational).
- `flush`  in  1  discard all buffered and in-flight words.
- `m_valid`  out  1  head word valid.
- `m_data`  out  WIDTH  head word.
- `m_ready`  in  1  consumer accepts head word.
- `buf_cnt`  out  2  words currently held (0..2), registered.
- `xfer_cnt`  out  CNT_W  words delivered since reset, registered.

## Operation
- **Definitions:**
  - pop = `m_valid && m_ready`.
  - inflight = 1-bit register, set when a read was issued in the previous cycle.
- **Read issue:** `fifo_rd_en = rst_n && !flush && !fifo_empty && (buf_cnt + inflight - pop) < 2`.
  - Issued reads are never gated by a stale empty flag.
  - A read is never issued when the buffer could not absorb its return.
- **Capture:** when inflight=1 and flush=0, `fifo_rd_data` is written into the buffer that cycle.
  - It goes to the head if the head is free or is being popped; otherwise it goes to the skid entry.
- **Buffer states** (`buf_cnt`):
  - **EMPTY (0):**
    - capture → ONE.
  - **ONE (1), head valid:**
    - pop without capture → EMPTY;
    - capture without pop → TWO;
    - pop and capture → ONE, with the new head taken from the capture.
  - **TWO (2), head and skid valid:**
    - pop → ONE, with skid moving to head;
    - capture never occurs in TWO (guaranteed by the issue rule; the bench asserts it).
- **Output stability:** while `m_valid=1` and `m_ready=0`, `m_data` is held constant.
- **Ordering:** strict FIFO order; skid is always older than any newer capture.
- **Flush:**
  - `m_valid` is forced to 0 during the flush cycle, so no pop is counted.
  - `fifo_rd_en` is 0.
  - Any word returning that cycle is discarded.
  - On the next edge: `buf_cnt` goes to 0 and inflight goes to 0.
  - `xfer_cnt` is not affected.
- **xfer_cnt:** increments by 1 on each pop; wraps modulo 2^CNT_W.

## Timing
- **Reset values** (edge with `rst_n=0`):
  - `m_valid`=0, `m_data`=0, `buf_cnt`=0, `xfer_cnt`=0, inflight=0;
  - `fifo_rd_en`=0 while `rst_n=0`.
- **Reset mid-operation:**
  - in-flight and buffered words are lost;
  - the FIFO is reset in the same cycle by system convention.
- **Latency:** `fifo_rd_en` in cycle N → word on `fifo_rd_data` in N+1 → `m_valid`/`m_data` in N+2.
- **First word:** `fifo_empty` falls in cycle N with `buf_cnt`=0 → `m_valid`=1 in N+2.
- **Throughput:** with `m_ready` held at 1 and the FIFO never empty, one pop per cycle indefinitely.
- **Back-pressure:** `m_ready` falls with one word in flight → that word lands in skid (`buf_cnt`=2) and reads stop.
  - When `m_ready` rises, reads resume in that same cycle (credit includes pop).
- **FIFO runs dry:** `m_valid` falls the cycle after the last buffered word pops; no bubble beyond the 2-cycle latency on refill.

## Test plan
- **Streaming:** write 0x1..0x10 to the FIFO, `m_ready`=1 → `m_data` shows 0x1..0x10 on 16 consecutive cycles; `xfer_cnt`=16; `fifo_rd_en` high 16 consecutive cycles.
- **Back-pressure:** 8 words queued, `m_ready` toggles 1,0,0,1,... →
  - all 8 words are delivered in order, with no loss or duplication;
  - `buf_cnt` never exceeds 2;
  - `m_data` is stable whenever `m_valid && !m_ready`.
- **Skid fill:** `m_ready`=0 from start, FIFO holds 5 words →
  - exactly 2 reads are issued;
  - `buf_cnt`=2, `m_data`=word0;
  - FIFO occupancy is 3;
  - then `m_ready`=1 → words 0..4 are delivered on 5 consecutive cycles.
- **Flush with word in flight:** issue a read in cycle N, assert `flush` in N+1 →
  - the returned word is discarded;
  - `m_valid`=0 in N+1 and N+2;
  - `buf_cnt`=0 in N+2;
  - the next FIFO word appears 2 cycles after its read.
- **Reset mid-stream:** `rst_n`=0 for 1 cycle with `buf_cnt`=2 →
  - next cycle: all outputs are 0;
  - `xfer_cnt`=0;
  - no `fifo_rd_en` during reset.
- **Counter wrap:** CNT_W=4, deliver 17 words → `xfer_cnt`=1.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Purpose: drains a registered-output sync FIFO into a 2-entry holding buffer and a valid/ready stream.
// Latency: fifo_rd_en in cycle N, word on fifo_rd_data in N+1, m_valid/m_data in N+2; one word per cycle sustained.
// Backpressure: reads are issued only when the buffer can absorb the return (credit counts held + in-flight - pop).
//
// Ports:
//   clk, rst_n      : rising-edge clock, synchronous active-low reset
//   fifo_empty      : FIFO empty flag (registered in the FIFO)
//   fifo_rd_data    : FIFO read data, meaningful the cycle after an accepted read
//   fifo_rd_en      : read request to the FIFO (combinational)
//   flush           : discard buffered and in-flight words this cycle
//   m_valid/m_data  : head word of the output stream
//   m_ready         : consumer accepts the head word
//   buf_cnt         : words currently held (0..2)
//   xfer_cnt        : words delivered since reset, wraps
module fifo_rd_stream #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             fifo_rd_en,
    input  logic             flush,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [1:0]       buf_cnt,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             inflight_q;
    logic [CNT_W-1:0] xfer_q, xfer_d;

    logic             pop;
    logic             capture;
    logic [2:0]       credit;

    // Flush masks the head so a word being discarded can never be counted as delivered.
    assign m_valid  = (cnt_q != 2'd0) && !flush;
    assign m_data   = head_q;
    assign buf_cnt  = cnt_q;
    assign xfer_cnt = xfer_q;

    assign pop     = m_valid && m_ready;
    assign capture = inflight_q && !flush;

    // Occupancy the buffer will have once the in-flight word lands and this cycle's pop
    // leaves. A new read is safe only if that leaves room for one more word. pop implies
    // cnt_q >= 1, so the subtraction cannot underflow.
    assign credit     = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = rst_n && !flush && !fifo_empty && (credit < 3'd2);

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        skid_d = skid_q;
        xfer_d = xfer_q + {{(CNT_W-1){1'b0}}, pop};

        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (capture) begin
                        head_d = fifo_rd_data;
                        cnt_d  = 2'd1;
                    end
                end
                2'd1: begin
                    if (pop && capture) begin
                        // Head leaves and the returning word replaces it directly.
                        head_d = fifo_rd_data;
                    end else if (pop) begin
                        cnt_d = 2'd0;
                    end else if (capture) begin
                        // Head is stalled: park the newer word behind it.
                        skid_d = fifo_rd_data;
                        cnt_d  = 2'd2;
                    end
                end
                default: begin
                    // Full: the issue rule guarantees no capture here, only a pop.
                    if (pop) begin
                        head_d = skid_q;
                        cnt_d  = 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= 2'd0;
            head_q     <= '0;
            skid_q     <= '0;
            inflight_q <= 1'b0;
            xfer_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            // fifo_rd_en is already 0 during flush, so this also clears inflight on flush.
            inflight_q <= fifo_rd_en;
            xfer_q     <= xfer_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         m_ready = 1'b0;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] fifo_rd_data = '0;

    logic         fifo_rd_en, m_valid;
    logic [W-1:0] m_data;
    logic [1:0]   buf_cnt;
    logic [31:0]  xfer_cnt;

    logic         fifo_rd_en4, m_valid4;
    logic [W-1:0] m_data4;
    logic [1:0]   buf_cnt4;
    logic [3:0]   xfer_cnt4;

    int checks = 0;
    int errors = 0;

    // Behavioural reference: the held words as a queue, plus one pending return.
    logic [W-1:0] mbuf[$];
    logic         m_infl = 1'b0;
    logic [W-1:0] m_infl_w = '0;
    logic [31:0]  m_xfer = '0;

    // Bench FIFO with registered empty flag and registered read data.
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] nxt_data = '0;
    logic         nxt_empty = 1'b1;

    // Observation logs used by the directed scenarios.
    int           cyc = 0;
    int           rd_cyc[$];
    logic [W-1:0] pop_log[$];
    int           pop_cyc[$];
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;

    logic         exp_vld, exp_pop, exp_rd;
    int           occ;

    always #5 clk = ~clk;

    fifo_rd_stream #(.WIDTH(W), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en), .flush(flush), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .buf_cnt(buf_cnt), .xfer_cnt(xfer_cnt)
    );

    fifo_rd_stream #(.WIDTH(W), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en4), .flush(flush), .m_valid(m_valid4), .m_data(m_data4),
        .m_ready(m_ready), .buf_cnt(buf_cnt4), .xfer_cnt(xfer_cnt4)
    );

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endfunction

    // Compare process: outputs are settled mid-cycle; then the model and FIFO advance.
    always @(negedge clk) begin
        exp_vld = !flush && (mbuf.size() > 0);
        exp_pop = exp_vld && m_ready;
        occ     = mbuf.size() + (m_infl ? 1 : 0) - (exp_pop ? 1 : 0);
        exp_rd  = rst_n && !flush && !fifo_empty && (occ < 2);

        chk("m_valid", 64'(m_valid), 64'(exp_vld));
        chk("fifo_rd_en", 64'(fifo_rd_en), 64'(exp_rd));
        chk("buf_cnt", 64'(buf_cnt), 64'(mbuf.size()));
        chk("xfer_cnt", 64'(xfer_cnt), 64'(m_xfer));
        chk("w4_m_valid", 64'(m_valid4), 64'(exp_vld));
        chk("w4_fifo_rd_en", 64'(fifo_rd_en4), 64'(exp_rd));
        chk("w4_buf_cnt", 64'(buf_cnt4), 64'(mbuf.size()));
        chk("w4_xfer_cnt", 64'(xfer_cnt4), 64'(m_xfer % 16));
        if (exp_vld) begin
            chk("m_data", 64'(m_data), 64'(mbuf[0]));
            chk("w4_m_data", 64'(m_data4), 64'(mbuf[0]));
        end
        if (prev_hold && m_valid) chk("m_data_stable", 64'(m_data), 64'(prev_data));
        prev_hold = rst_n && m_valid && !m_ready;
        prev_data = m_data;

        if (fifo_rd_en) rd_cyc.push_back(cyc);
        if (m_valid && m_ready) begin
            pop_log.push_back(m_data);
            pop_cyc.push_back(cyc);
        end

        // Reference model advance.
        if (!rst_n) begin
            mbuf.delete();
            m_infl = 1'b0;
            m_xfer = '0;
        end else if (flush) begin
            mbuf.delete();
            m_infl = 1'b0;
        end else begin
            if (exp_pop) begin
                void'(mbuf.pop_front());
                m_xfer = m_xfer + 32'd1;
            end
            if (m_infl) begin
                if (mbuf.size() >= 2) begin
                    errors++;
                    $display("FAIL capture_in_two cycle=%0d held=%0d required_below=2", cyc, mbuf.size());
                end
                mbuf.push_back(m_infl_w);
            end
            m_infl = exp_rd;
            if (exp_rd && fifo_q.size() > 0) m_infl_w = fifo_q[0];
        end

        // FIFO advance, driven by what the DUT actually requested.
        if (!rst_n) begin
            fifo_q.delete();
            nxt_data = '0;
        end else if (fifo_rd_en) begin
            if (fifo_q.size() == 0) begin
                errors++;
                $display("FAIL read_on_empty cycle=%0d fifo_rd_en=1 required=0", cyc);
                nxt_data = $urandom;
            end else begin
                nxt_data = fifo_q.pop_front();
            end
        end else begin
            nxt_data = $urandom;  // read data is garbage unless a read was accepted
        end
        nxt_empty = (fifo_q.size() == 0);
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        fifo_rd_data = nxt_data;
        fifo_empty   = nxt_empty;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_logs();
        rd_cyc.delete();
        pop_log.delete();
        pop_cyc.delete();
    endtask

    initial begin
        // Reset
        run(2);
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_buf_cnt", 64'(buf_cnt), 64'd0);
        chk("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        rst_n = 1'b1;
        tick();

        // Streaming 0x1..0x10
        m_ready = 1'b1;
        clear_logs();
        for (int i = 1; i <= 16; i++) fifo_q.push_back(32'(i));
        run(22);
        chk("stream_rd_count", 64'(rd_cyc.size()), 64'd16);
        chk("stream_rd_contig", 64'((rd_cyc.size() >= 16) ? rd_cyc[15] - rd_cyc[0] : -1), 64'd15);
        chk("stream_pop_count", 64'(pop_log.size()), 64'd16);
        for (int i = 0; i < 16 && i < pop_log.size(); i++) chk("stream_data", 64'(pop_log[i]), 64'(i + 1));
        chk("stream_pop_contig", 64'((pop_cyc.size() >= 16) ? pop_cyc[15] - pop_cyc[0] : -1), 64'd15);
        chk("stream_latency", 64'((pop_cyc.size() > 0 && rd_cyc.size() > 0) ? pop_cyc[0] - rd_cyc[0] : -1), 64'd2);
        chk("stream_xfer", 64'(xfer_cnt), 64'd16);

        // Back-pressure: m_ready pattern 1,0,0,1
        clear_logs();
        for (int i = 0; i < 8; i++) fifo_q.push_back(32'h100 + 32'(i));
        for (int c = 0; c < 40; c++) begin
            m_ready = (c % 4 == 0) || (c % 4 == 3);
            tick();
        end
        chk("bp_pop_count", 64'(pop_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < pop_log.size(); i++) chk("bp_data", 64'(pop_log[i]), 64'(32'h100 + 32'(i)));

        // Skid fill
        m_ready = 1'b0;
        clear_logs();
        for (int i = 0; i < 5; i++) fifo_q.push_back(32'hA0 + 32'(i));
        run(6);
        #1;
        chk("skid_rd_count", 64'(rd_cyc.size()), 64'd2);
        chk("skid_buf_cnt", 64'(buf_cnt), 64'd2);
        chk("skid_head", 64'(m_data), 64'hA0);
        chk("skid_fifo_occ", 64'(fifo_q.size()), 64'd3);
        clear_logs();
        m_ready = 1'b1;
        run(8);
        chk("skid_pop_count", 64'(pop_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < pop_log.size(); i++) chk("skid_data", 64'(pop_log[i]), 64'(32'hA0 + 32'(i)));
        chk("skid_pop_contig", 64'((pop_cyc.size() >= 5) ? pop_cyc[4] - pop_cyc[0] : -1), 64'd4);

        // Flush with a word in flight
        clear_logs();
        fifo_q.push_back(32'hF1);
        tick(); #1;
        chk("flush_rd_issue", 64'(fifo_rd_en), 64'd1);
        tick(); flush = 1'b1; #1;
        chk("flush_m_valid_n1", 64'(m_valid), 64'd0);
        chk("flush_rd_en", 64'(fifo_rd_en), 64'd0);
        tick(); flush = 1'b0; #1;
        chk("flush_m_valid_n2", 64'(m_valid), 64'd0);
        chk("flush_buf_cnt_n2", 64'(buf_cnt), 64'd0);
        fifo_q.push_back(32'hF2);
        tick(); #1;
        chk("flush_next_rd", 64'(fifo_rd_en), 64'd1);
        tick(); #1;
        chk("flush_next_lat1", 64'(m_valid), 64'd0);
        tick(); #1;
        chk("flush_next_valid", 64'(m_valid), 64'd1);
        chk("flush_next_data", 64'(m_data), 64'hF2);
        run(2);
        chk("flush_pop_count", 64'(pop_log.size()), 64'd1);

        // Reset mid-stream with the buffer full
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'hC0 + 32'(i));
        run(5); #1;
        chk("mid_rst_pre_cnt", 64'(buf_cnt), 64'd2);
        rst_n = 1'b0; #1;
        chk("mid_rst_rd_en", 64'(fifo_rd_en), 64'd0);
        tick(); rst_n = 1'b1; #1;
        chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_m_data", 64'(m_data), 64'd0);
        chk("mid_rst_buf_cnt", 64'(buf_cnt), 64'd0);
        chk("mid_rst_xfer", 64'(xfer_cnt), 64'd0);
        chk("mid_rst_xfer_w4", 64'(xfer_cnt4), 64'd0);

        // Counter wrap on the 4-bit instance
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) fifo_q.push_back(32'hD00 + 32'(i));
        run(24);
        chk("wrap_xfer32", 64'(xfer_cnt), 64'd17);
        chk("wrap_xfer4", 64'(xfer_cnt4), 64'd1);

        // Randomized traffic, back-pressure and flushes
        for (int c = 0; c < 800; c++) begin
            m_ready = ($urandom_range(0, 9) < 6);
            flush   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) < 4) fifo_q.push_back($urandom);
            if ($urandom_range(0, 9) == 0) fifo_q.push_back($urandom);
            tick();
        end
        flush = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 3000 && (fifo_q.size() > 0 || m_valid); i++) tick();
        run(4); #1;
        chk("drain_fifo_empty", 64'(fifo_q.size()), 64'd0);
        chk("drain_buf_cnt", 64'(buf_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
